// File: rtl/cv32e40p_tb_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40p_tb_arb_pkg
// Shared types for the TB memory arbiter: requester IDs, arbiter FSM states
// and the round-robin selection function.
// ----------------------------------------------------------------------------
package cv32e40p_tb_arb_pkg;

    typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} arb_src_e;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

    // One requester wins outright; on a tie the one that was not served last wins.
    function automatic arb_src_e rr_pick(input logic instr_req,
                                         input logic data_req,
                                         input arb_src_e last_src);
        arb_src_e pick;
        if (instr_req && data_req) begin
            pick = (last_src == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        end else if (instr_req) begin
            pick = SRC_INSTR;
        end else begin
            pick = SRC_DATA;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cv32e40p_tb_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cv32e40p_tb_mem_arbiter_if
// OBI-style request/response bundle used for the fetch, LSU and memory sides
// of the arbiter.
//   req/addr/we/be/wdata : request phase, driven by the master
//   gnt                  : request accepted, driven by the slave
//   rvalid/rdata         : in-order response, driven by the slave
// Modports: master, slave, slave_ro (read-only requester without write fields).
// ----------------------------------------------------------------------------
interface cv32e40p_tb_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      gnt;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

    modport slave_ro (
        input  req, addr,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/cv32e40p_tb_mem_arbiter_id_fifo.sv
// ----------------------------------------------------------------------------
// cv32e40p_tb_arb_id_fifo
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
//   clk_i, rst_i : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_id: enqueue an ID (ignored when full)
//   pop          : dequeue the head (ignored when empty)
//   full, empty  : occupancy flags from the current (pre-update) count
//   head         : ID of the oldest entry
// ----------------------------------------------------------------------------
module cv32e40p_tb_arb_id_fifo
    import cv32e40p_tb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push,
    input  arb_src_e push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output arb_src_e head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    arb_src_e         ids_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = ids_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ids_q[i] <= SRC_INSTR;
            end
        end else begin
            if (do_push) begin
                ids_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cv32e40p_tb_mem_arbiter
// Round-robin arbiter sharing one OBI memory port between the core fetch
// (read-only) and LSU ports, with zero added latency on either path.
// Responses are steered back to their issuer through an in-order ID FIFO.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   instr         : fetch requester (slave_ro)
//   data          : LSU requester (slave)
//   mem           : shared memory port (master)
//   err_rvalid_o  : sticky, memory response seen with nothing outstanding
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ARB_IDLE   | free to pick a requester each cycle by round-robin
// ARB_LOCKED | request presented but not granted; selection frozen until gnt
// ----------------------------------------------------------------------------
module cv32e40p_tb_mem_arbiter
    import cv32e40p_tb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cv32e40p_tb_mem_arbiter_if.slave_ro instr,
    cv32e40p_tb_mem_arbiter_if.slave    data,
    cv32e40p_tb_mem_arbiter_if.master   mem,
    output logic                        err_rvalid_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    arb_src_e   sel_q;
    arb_src_e   sel;
    arb_src_e   last_src_q;
    arb_src_e   head_src;
    logic       fifo_full;
    logic       fifo_empty;
    logic       any_req;
    logic       mem_req_raw;
    logic       handshake;
    logic       rsp_valid;

    assign any_req = instr.req | data.req;

    always_comb begin
        sel = sel_q;
        if (state_q == ARB_IDLE) begin
            sel = rr_pick(instr.req, data.req, last_src_q);
        end
    end

    // Full is evaluated on the pre-pop count, so a same-cycle pop never lets a
    // new grant through at full. LOCKED cannot be entered while full.
    assign mem_req_raw = (state_q == ARB_LOCKED) ? 1'b1 : (any_req & ~fifo_full);

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign mem.req   = ~rst_i & mem_req_raw;
    assign mem.addr  = rst_i ? {ADDR_WIDTH{1'b0}}
                             : ((sel == SRC_INSTR) ? instr.addr : data.addr);
    assign mem.we    = ~rst_i & (sel == SRC_DATA) & data.we;
    assign mem.be    = rst_i ? {(DATA_WIDTH/8){1'b0}}
                             : ((sel == SRC_INSTR) ? {(DATA_WIDTH/8){1'b1}} : data.be);
    assign mem.wdata = (rst_i || sel == SRC_INSTR) ? {DATA_WIDTH{1'b0}} : data.wdata;

    assign handshake = mem.req & mem.gnt;
    assign instr.gnt = handshake & (sel == SRC_INSTR);
    assign data.gnt  = handshake & (sel == SRC_DATA);

    assign rsp_valid    = ~rst_i & mem.rvalid & ~fifo_empty;
    assign instr.rvalid = rsp_valid & (head_src == SRC_INSTR);
    assign data.rvalid  = rsp_valid & (head_src == SRC_DATA);
    assign instr.rdata  = rst_i ? {DATA_WIDTH{1'b0}} : mem.rdata;
    assign data.rdata   = rst_i ? {DATA_WIDTH{1'b0}} : mem.rdata;

    cv32e40p_tb_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (handshake),
        .push_id (sel),
        .pop     (mem.rvalid),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_src)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (mem.req && !mem.gnt) state_d = ARB_LOCKED;
            ARB_LOCKED: if (mem.gnt)             state_d = ARB_IDLE;
            default:                             state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            sel_q      <= SRC_DATA;
            last_src_q <= SRC_DATA;
        end else begin
            state_q <= state_d;
            sel_q   <= sel;
            if (handshake) begin
                last_src_q <= sel;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_rvalid_o <= 1'b0;
        end else if (mem.rvalid && fifo_empty) begin
            err_rvalid_o <= 1'b1;
        end
    end

    // A requester must hold its request until granted once the port is locked to it.
    a_req_held_while_locked: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_LOCKED) |-> ((sel_q == SRC_INSTR) ? instr.req : data.req)
    );

endmodule

// File: tb/tb_cv32e40p_tb_mem_arbiter.sv
module tb_cv32e40p_tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_rvalid;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cv32e40p_tb_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) instr_bus ();
    cv32e40p_tb_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) data_bus ();
    cv32e40p_tb_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    cv32e40p_tb_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .instr        (instr_bus),
        .data         (data_bus),
        .mem          (mem_bus),
        .err_rvalid_o (err_rvalid)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_bus.req   = 1'b0;
        instr_bus.addr  = '0;
        instr_bus.we    = 1'b0;
        instr_bus.be    = '0;
        instr_bus.wdata = '0;
        data_bus.req    = 1'b0;
        data_bus.addr   = '0;
        data_bus.we     = 1'b0;
        data_bus.be     = '0;
        data_bus.wdata  = '0;
        mem_bus.gnt     = 1'b0;
        mem_bus.rvalid  = 1'b0;
        mem_bus.rdata   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        instr_bus.req = 1'b1;
        data_bus.req  = 1'b1;
        mem_bus.gnt   = 1'b1;
        #2;
        vectors++;
        if (mem_bus.req !== 1'b0) begin
            miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_bus.req);
        end
        vectors++;
        if ({instr_bus.gnt, data_bus.gnt, instr_bus.rvalid, data_bus.rvalid} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_gnt_rvalid: got %b want 0000",
                {instr_bus.gnt, data_bus.gnt, instr_bus.rvalid, data_bus.rvalid});
        end
        vectors++;
        if (err_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL reset_err: got %b want 0", err_rvalid);
        end
        do_reset();
    endtask

    task automatic test_instr_read();
        instr_bus.req  = 1'b1;
        instr_bus.addr = 32'h0000_0180;
        mem_bus.gnt    = 1'b1;
        #1;
        vectors++;
        if ({mem_bus.req, instr_bus.gnt, data_bus.gnt} !== 3'b110) begin
            miscompares++; $display("FAIL t1_req_gnt: got %b want 110",
                {mem_bus.req, instr_bus.gnt, data_bus.gnt});
        end
        vectors++;
        if (mem_bus.addr !== 32'h0000_0180) begin
            miscompares++; $display("FAIL t1_addr: got %h want 00000180", mem_bus.addr);
        end
        vectors++;
        if ({mem_bus.we, mem_bus.be} !== 5'b0_1111 || mem_bus.wdata !== 32'h0) begin
            miscompares++; $display("FAIL t1_we_be_wdata: got %b %b %h want 0 1111 0",
                mem_bus.we, mem_bus.be, mem_bus.wdata);
        end
        next_cycle();
        instr_bus.req  = 1'b0;
        mem_bus.gnt    = 1'b0;
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if ({instr_bus.rvalid, data_bus.rvalid} !== 2'b10) begin
            miscompares++; $display("FAIL t1_rvalid: got %b want 10",
                {instr_bus.rvalid, data_bus.rvalid});
        end
        vectors++;
        if (instr_bus.rdata !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL t1_rdata: got %h want deadbeef", instr_bus.rdata);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_i;
        logic prev_i;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            instr_bus.req  = (k < 4);
            instr_bus.addr = 32'h0000_0400 + 32'(4 * k);
            data_bus.req   = (k < 4);
            data_bus.addr  = 32'h0000_2000 + 32'(4 * k);
            mem_bus.gnt    = (k < 4);
            mem_bus.rvalid = (k > 0);
            mem_bus.rdata  = 32'h0000_0100 + 32'(k);
            #1;
            if (k < 4) begin
                exp_i = (k % 2 == 0);
                vectors++;
                if ({instr_bus.gnt, data_bus.gnt} !== {exp_i, ~exp_i}) begin
                    miscompares++; $display("FAIL t2_gnt[%0d]: got %b want %b",
                        k, {instr_bus.gnt, data_bus.gnt}, {exp_i, ~exp_i});
                end
                vectors++;
                if (mem_bus.addr !== (exp_i ? instr_bus.addr : data_bus.addr)) begin
                    miscompares++; $display("FAIL t2_addr[%0d]: got %h want %h",
                        k, mem_bus.addr, exp_i ? instr_bus.addr : data_bus.addr);
                end
            end
            if (k > 0) begin
                prev_i = ((k - 1) % 2 == 0);
                vectors++;
                if ({instr_bus.rvalid, data_bus.rvalid} !== {prev_i, ~prev_i}) begin
                    miscompares++; $display("FAIL t2_rvalid[%0d]: got %b want %b",
                        k, {instr_bus.rvalid, data_bus.rvalid}, {prev_i, ~prev_i});
                end
                vectors++;
                if (data_bus.rdata !== 32'h0000_0100 + 32'(k)) begin
                    miscompares++; $display("FAIL t2_rdata[%0d]: got %h want %h",
                        k, data_bus.rdata, 32'h0000_0100 + 32'(k));
                end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_locked_write();
        // last_src is DATA here, so a tie in IDLE would pick instr.
        data_bus.req   = 1'b1;
        data_bus.addr  = 32'h0000_1000;
        data_bus.we    = 1'b1;
        data_bus.be    = 4'b0011;
        data_bus.wdata = 32'hCAFE_F00D;
        mem_bus.gnt    = 1'b0;
        #1;
        vectors++;
        if ({mem_bus.req, mem_bus.we, mem_bus.be, data_bus.gnt} !== 7'b1_1_0011_0) begin
            miscompares++; $display("FAIL t3_first: got %b want 1100110",
                {mem_bus.req, mem_bus.we, mem_bus.be, data_bus.gnt});
        end
        for (int k = 1; k < 4; k++) begin
            next_cycle();
            instr_bus.req  = 1'b1;
            instr_bus.addr = 32'h0000_0300;
            mem_bus.gnt    = (k == 3);
            #1;
            vectors++;
            if (mem_bus.addr !== 32'h0000_1000 || mem_bus.wdata !== 32'hCAFE_F00D) begin
                miscompares++; $display("FAIL t3_stable[%0d]: got %h %h want 00001000 cafef00d",
                    k, mem_bus.addr, mem_bus.wdata);
            end
            vectors++;
            if ({instr_bus.gnt, data_bus.gnt} !== {1'b0, (k == 3)}) begin
                miscompares++; $display("FAIL t3_gnt[%0d]: got %b want %b",
                    k, {instr_bus.gnt, data_bus.gnt}, {1'b0, (k == 3)});
            end
        end
        next_cycle();
        data_bus.req   = 1'b0;
        data_bus.we    = 1'b0;
        mem_bus.gnt    = 1'b1;
        mem_bus.rvalid = 1'b1;
        #1;
        vectors++;
        if ({instr_bus.gnt, mem_bus.addr} !== {1'b1, 32'h0000_0300}) begin
            miscompares++; $display("FAIL t3_idle_again: got %b %h want 1 00000300",
                instr_bus.gnt, mem_bus.addr);
        end
        vectors++;
        if ({instr_bus.rvalid, data_bus.rvalid} !== 2'b01) begin
            miscompares++; $display("FAIL t3_wr_rsp: got %b want 01",
                {instr_bus.rvalid, data_bus.rvalid});
        end
        next_cycle();
        instr_bus.req = 1'b0;
        mem_bus.gnt   = 1'b0;
        #1;
        vectors++;
        if ({instr_bus.rvalid, data_bus.rvalid} !== 2'b10) begin
            miscompares++; $display("FAIL t3_rd_rsp: got %b want 10",
                {instr_bus.rvalid, data_bus.rvalid});
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_outstanding_limit();
        logic [1:0] exp_req_gnt [6];
        exp_req_gnt = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
        for (int k = 0; k < 6; k++) begin
            instr_bus.req  = 1'b1;
            instr_bus.addr = 32'h0000_0400;
            mem_bus.gnt    = 1'b1;
            mem_bus.rvalid = (k == 4);
            mem_bus.rdata  = 32'h0000_0044;
            #1;
            vectors++;
            if ({mem_bus.req, instr_bus.gnt} !== exp_req_gnt[k]) begin
                miscompares++; $display("FAIL t4_req_gnt[%0d]: got %b want %b",
                    k, {mem_bus.req, instr_bus.gnt}, exp_req_gnt[k]);
            end
            if (k == 4) begin
                vectors++;
                if (instr_bus.rvalid !== 1'b1) begin
                    miscompares++; $display("FAIL t4_rvalid: got %b want 1", instr_bus.rvalid);
                end
            end
            next_cycle();
        end
        instr_bus.req = 1'b0;
        mem_bus.gnt   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_bus.rvalid = 1'b1;
            #1;
            vectors++;
            if ({instr_bus.rvalid, data_bus.rvalid} !== 2'b10) begin
                miscompares++; $display("FAIL t4_drain[%0d]: got %b want 10",
                    k, {instr_bus.rvalid, data_bus.rvalid});
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        vectors++;
        if (err_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL t4_err: got %b want 0", err_rvalid);
        end
    endtask

    task automatic test_stray_rvalid();
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 32'h0000_0055;
        #1;
        vectors++;
        if ({instr_bus.rvalid, data_bus.rvalid} !== 2'b00) begin
            miscompares++; $display("FAIL t5_dropped: got %b want 00",
                {instr_bus.rvalid, data_bus.rvalid});
        end
        next_cycle();
        mem_bus.rvalid = 1'b0;
        vectors++;
        if (err_rvalid !== 1'b1) begin
            miscompares++; $display("FAIL t5_err_set: got %b want 1", err_rvalid);
        end
        repeat (3) next_cycle();
        vectors++;
        if (err_rvalid !== 1'b1) begin
            miscompares++; $display("FAIL t5_err_sticky: got %b want 1", err_rvalid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (err_rvalid !== 1'b0) begin
            miscompares++; $display("FAIL t5_err_clear: got %b want 0", err_rvalid);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        instr_bus.req  = 1'b1;
        instr_bus.addr = 32'h0000_0500;
        data_bus.req   = 1'b1;
        data_bus.addr  = 32'h0000_3000;
        mem_bus.gnt    = 1'b1;
        #1;
        vectors++;
        if ({instr_bus.gnt, data_bus.gnt} !== 2'b10) begin
            miscompares++; $display("FAIL t6_gnt0: got %b want 10", {instr_bus.gnt, data_bus.gnt});
        end
        next_cycle();
        #1;
        vectors++;
        if ({instr_bus.gnt, data_bus.gnt} !== 2'b01) begin
            miscompares++; $display("FAIL t6_gnt1: got %b want 01", {instr_bus.gnt, data_bus.gnt});
        end
        next_cycle();
        #1;
        vectors++;
        if (mem_bus.req !== 1'b0) begin
            miscompares++; $display("FAIL t6_full: got %b want 0", mem_bus.req);
        end
        mem_bus.rvalid = 1'b1;
        mem_bus.rdata  = 32'h0000_0066;
        rst = 1'b1;
        #1;
        vectors++;
        if ({mem_bus.req, mem_bus.we, instr_bus.gnt, data_bus.gnt,
             instr_bus.rvalid, data_bus.rvalid, err_rvalid} !== 7'b0) begin
            miscompares++; $display("FAIL t6_async_zero: got %b want 0000000",
                {mem_bus.req, mem_bus.we, instr_bus.gnt, data_bus.gnt,
                 instr_bus.rvalid, data_bus.rvalid, err_rvalid});
        end
        vectors++;
        if ({mem_bus.addr, mem_bus.be, data_bus.rdata} !== 68'h0) begin
            miscompares++; $display("FAIL t6_async_bus: got %h %b %h want 0 0 0",
                mem_bus.addr, mem_bus.be, data_bus.rdata);
        end
        next_cycle();
        rst            = 1'b0;
        instr_bus.req  = 1'b0;
        data_bus.req   = 1'b0;
        mem_bus.gnt    = 1'b0;
        mem_bus.rvalid = 1'b1;
        #1;
        vectors++;
        if ({instr_bus.rvalid, data_bus.rvalid} !== 2'b00) begin
            miscompares++; $display("FAIL t6_post_rvalid: got %b want 00",
                {instr_bus.rvalid, data_bus.rvalid});
        end
        next_cycle();
        mem_bus.rvalid = 1'b0;
        vectors++;
        if (err_rvalid !== 1'b1) begin
            miscompares++; $display("FAIL t6_err: got %b want 1", err_rvalid);
        end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_instr_read();
        test_round_robin();
        test_locked_write();
        test_outstanding_limit();
        test_stray_rvalid();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
